uart_rx_ctrl: RTL and testbench

UART receiver for the low-speed peripheral domain: it oversamples the asynchronous `uart_rx` pad line, decodes 8-bit frames (optional parity, one stop bit), and buffers received bytes in a show-ahead FIFO. Software or the bus-side wrapper pops bytes through a valid/ready handshake. It is the receive-side counterpart of the UART transmitter driving `uart_tx`. It is instantiated inside `soc_top` on the `low_peri_clk` / `low_peri_rst_n` pair.

---
 rtl/uart_rx_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop line synchronizer, mid-bit sampling frame decoder (8 data bits,
// optional parity, one stop bit) and a show-ahead receive FIFO with valid/ready pop.
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          low_peri_clk,
  input  logic                          low_peri_rst_n,
  input  logic                          uart_rx,
  input  logic [15:0]                   baud_div,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t        state, state_nxt;
  logic          rx_sync_p0, rxs;
  logic [15:0]   baud_eff, cnt;
  logic          cnt_zero;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bad;
  logic          load_half, load_full, shift_en, par_chk, clr_idx;
  logic          push, fe_set, pe_set;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, wr_en;

  assign baud_eff = (baud_div < 16'd3) ? 16'd3 : baud_div;
  assign cnt_zero = (cnt == 16'd0);

  // Synchronizer: both stages reset to the idle (high) line level
  always_ff @(posedge low_peri_clk or negedge low_peri_rst_n) begin
    if (!low_peri_rst_n) begin
      rx_sync_p0 <= 1'b1;
      rxs        <= 1'b1;
    end else begin
      rx_sync_p0 <= uart_rx;
      rxs        <= rx_sync_p0;
    end
  end

  always_ff @(posedge low_peri_clk or negedge low_peri_rst_n) begin
    if (!low_peri_rst_n) state <= IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rxs) state_nxt = START;
      START:     if (cnt_zero) state_nxt = rxs ? IDLE : DATA;
      DATA:      if (cnt_zero && bit_idx == 3'd7) state_nxt = parity_en ? PARITY : STOP;
      PARITY:    if (cnt_zero) state_nxt = STOP;
      STOP:      if (cnt_zero) state_nxt = rxs ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxs) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // A frame error takes precedence over a recorded parity mismatch
  always_comb begin
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    par_chk   = 1'b0;
    clr_idx   = 1'b0;
    push      = 1'b0;
    fe_set    = 1'b0;
    pe_set    = 1'b0;
    case (state)
      IDLE:   load_half = !rxs;
      START:  if (cnt_zero && !rxs) begin
                load_full = 1'b1;
                clr_idx   = 1'b1;
              end
      DATA:   if (cnt_zero) begin
                shift_en  = 1'b1;
                load_full = 1'b1;
              end
      PARITY: if (cnt_zero) begin
                par_chk   = 1'b1;
                load_full = 1'b1;
              end
      STOP:   if (cnt_zero) begin
                if (!rxs)        fe_set = 1'b1;
                else if (par_bad) pe_set = 1'b1;
                else             push   = 1'b1;
              end
      default: ;
    endcase
  end

  always_ff @(posedge low_peri_clk or negedge low_peri_rst_n) begin
    if (!low_peri_rst_n) begin
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
      par_bad <= 1'b0;
    end else begin
      if (load_half)      cnt <= baud_eff >> 1;
      else if (load_full) cnt <= baud_eff;
      else if (!cnt_zero) cnt <= cnt - 16'd1;
      if (clr_idx) begin
        bit_idx <= 3'd0;
        par_bad <= 1'b0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (par_chk) par_bad <= rxs ^ (^shreg) ^ parity_odd;
    end
  end

  always_ff @(posedge low_peri_clk) begin
    if (shift_en) shreg <= {rxs, shreg[7:1]};
  end

  // Receive FIFO: a pop frees the head slot, so a push into a full FIFO is kept when popping
  assign full     = (fifo_cnt == FULL_CNT);
  assign rx_valid = (fifo_cnt != '0);
  assign pop      = rx_valid & rx_ready;
  assign wr_en    = push & (!full | pop);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge low_peri_clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge low_peri_clk or negedge low_peri_rst_n) begin
    if (!low_peri_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: ;
      endcase
      frame_err  <= fe_set;
      parity_err <= pe_set;
      overrun    <= push & full & !pop;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are serialised at bit level, expected bytes and
// error counts come from a frame-level model; a negedge monitor checks every pop and pulse.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        uart_rx = 1'b1;
  logic [15:0] baud_div = 16'd9;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_err, parity_err, overrun;
  logic [3:0]  fifo_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int exp_fe = 0, exp_pe = 0, exp_ov = 0;
  int got_fe = 0, got_pe = 0, got_ov = 0;
  logic [7:0] exp_q[$];
  bit rand_ready = 1'b0;

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .low_peri_clk  (clk),
    .low_peri_rst_n(rst_n),
    .uart_rx       (uart_rx),
    .baud_div      (baud_div),
    .parity_en     (parity_en),
    .parity_odd    (parity_odd),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .frame_err     (frame_err),
    .parity_err    (parity_err),
    .overrun       (overrun),
    .fifo_cnt      (fifo_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops are compared against the scoreboard; each pulse cycle is counted
  always @(negedge clk) begin
    if (frame_err === 1'b1)  got_fe++;
    if (parity_err === 1'b1) got_pe++;
    if (overrun === 1'b1)    got_ov++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no data", rx_data);
      end else begin
        chk("pop_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic int period();
    return ((baud_div < 16'd3) ? 3 : int'(baud_div)) + 1;
  endfunction

  task automatic check_counts(input string tag);
    chk({tag, "_frame_err_cnt"}, got_fe, exp_fe);
    chk({tag, "_parity_err_cnt"}, got_pe, exp_pe);
    chk({tag, "_overrun_cnt"}, got_ov, exp_ov);
  endtask

  // Bit-level serialiser. abort_at >= 0 asserts reset mid-way through that bit and stops.
  task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_v,
                            input int abort_at, input bit pop_at_stop, input bit chk_lat);
    logic [10:0] fr;
    logic par;
    int nb, p, h;
    p = period();
    h = (p - 1) / 2;
    par = (^d) ^ parity_odd ^ par_flip;
    if (parity_en) begin
      fr = {stop_v, par, d, 1'b0};
      nb = 11;
    end else begin
      fr = {1'b0, stop_v, d, 1'b0};
      nb = 10;
    end
    for (int b = 0; b < nb; b++) begin
      uart_rx = fr[b];
      for (int k = 0; k < p; k++) begin
        if (b == abort_at && k == p / 2) begin
          rst_n = 1'b0;
          uart_rx = 1'b1;
          #1;
          chk("rst_rx_valid", {31'd0, rx_valid}, 0);
          chk("rst_rx_data", {24'd0, rx_data}, 0);
          chk("rst_fifo_cnt", {28'd0, fifo_cnt}, 0);
          chk("rst_pulses", {29'd0, frame_err, parity_err, overrun}, 0);
          exp_q.delete();
          repeat (3) tick();
          rst_n = 1'b1;
          repeat (4) tick();
          return;
        end
        if (b == nb - 1) begin
          if (pop_at_stop) rx_ready = (k == 3 + h);
          if (chk_lat && k == 3 + h) chk("valid_before_push", {31'd0, rx_valid}, 0);
          if (chk_lat && k == 4 + h) chk("valid_after_push", {31'd0, rx_valid}, 1);
        end
        tick();
      end
    end
    uart_rx = 1'b1;
    if (pop_at_stop) rx_ready = 1'b0;
    repeat (4) tick();
  endtask

  // Frame-level model: decide the outcome of a frame from its contents, then send it
  task automatic frame(input logic [7:0] d, input bit par_flip, input bit stop_v,
                       input bit pop_at_stop, input bit chk_lat);
    if (!stop_v) exp_fe++;
    else if (parity_en && par_flip) exp_pe++;
    else if (exp_q.size() < DEPTH || pop_at_stop) exp_q.push_back(d);
    else exp_ov++;
    send_frame(d, par_flip, stop_v, -1, pop_at_stop, chk_lat);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    rx_ready = 1'b1;
    while (rx_valid && guard < 50) begin
      tick();
      guard++;
    end
    rx_ready = 1'b0;
    tick();
    chk({tag, "_drain_cnt"}, {28'd0, fifo_cnt}, 0);
    chk({tag, "_scoreboard_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_rx_valid", {31'd0, rx_valid}, 0);
    chk("reset_rx_data", {24'd0, rx_data}, 0);
    chk("reset_fifo_cnt", {28'd0, fifo_cnt}, 0);
    chk("reset_pulses", {29'd0, frame_err, parity_err, overrun}, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Nominal byte with push latency check
    baud_div = 16'd9;
    parity_en = 1'b0;
    frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("nom_fifo_cnt", {28'd0, fifo_cnt}, 1);
    chk("nom_rx_valid", {31'd0, rx_valid}, 1);
    chk("nom_rx_data", {24'd0, rx_data}, 32'hA5);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("nom_cnt_after_pop", {28'd0, fifo_cnt}, 0);

    // Glitch shorter than half a bit
    uart_rx = 1'b0;
    repeat (3) tick();
    uart_rx = 1'b1;
    repeat (30) tick();
    chk("glitch_fifo_cnt", {28'd0, fifo_cnt}, 0);
    check_counts("glitch");

    // Odd parity on 0x03: wrong bit then correct bit
    parity_en = 1'b1;
    parity_odd = 1'b1;
    frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("parity_bad_cnt", {28'd0, fifo_cnt}, 0);
    check_counts("parity_bad");
    frame(8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("parity_good_cnt", {28'd0, fifo_cnt}, 1);
    drain("parity");

    // Break for 20 bit periods, then a good frame
    parity_en = 1'b0;
    exp_fe++;
    uart_rx = 1'b0;
    repeat (20 * period()) tick();
    uart_rx = 1'b1;
    repeat (period()) tick();
    chk("break_fifo_cnt", {28'd0, fifo_cnt}, 0);
    check_counts("break");
    frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    drain("after_break");

    // Overrun on the ninth byte
    for (int i = 0; i < 9; i++) frame(8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovr_fifo_cnt", {28'd0, fifo_cnt}, 8);
    check_counts("ovr");
    drain("ovr");

    // Ninth push coincides with a pop while full
    for (int i = 0; i < 8; i++) frame(8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    frame(8'h08, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("pushpop_fifo_cnt", {28'd0, fifo_cnt}, 8);
    check_counts("pushpop");
    drain("pushpop");

    // Reset during data bit 4 with two bytes queued
    frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h77, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_cnt", {28'd0, fifo_cnt}, 1);
    chk("post_rst_data", {24'd0, rx_data}, 32'h5A);
    drain("post_rst");

    // Randomized frames, baud rates (including clamped values), parity modes and errors
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      baud_div   = 16'($urandom_range(0, 14));
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      frame(8'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) != 0), 1'b0, 1'b0);
    end
    rand_ready = 1'b0;
    drain("random");
    check_counts("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
